// File: rtl/mu02_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mu02_if : single-port memory req/ack bus between mu02 and a memory.    |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
interface mu02_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface
`default_nettype wire

// File: rtl/mu02.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mu02 : parametrised accumulator processor on an external req/ack       |
// | memory. MU02_SIGN_EXT_EN selects sign-extended immediates.             |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module mu02 #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  mu02_if.master            bus,
  output logic              halted,
  output logic              illegal,
  output logic [ADDR_W-1:0] pc_o,
  output logic [DATA_W-1:0] acc_o
);
  localparam int OPND_W = DATA_W - 4;

  localparam logic [1:0] c_FETCH = 2'd0;
  localparam logic [1:0] c_EXEC  = 2'd1;
  localparam logic [1:0] c_MEM   = 2'd2;
  localparam logic [1:0] c_HALT  = 2'd3;

  localparam logic [3:0] c_LDA  = 4'b0000;
  localparam logic [3:0] c_STO  = 4'b0001;
  localparam logic [3:0] c_ADD  = 4'b0010;
  localparam logic [3:0] c_SUB  = 4'b0011;
  localparam logic [3:0] c_JMP  = 4'b0100;
  localparam logic [3:0] c_JGE  = 4'b0101;
  localparam logic [3:0] c_JNE  = 4'b0110;
  localparam logic [3:0] c_STP  = 4'b0111;
  localparam logic [3:0] c_LDAI = 4'b1000;
  localparam logic [3:0] c_ADDI = 4'b1010;
  localparam logic [3:0] c_SUBI = 4'b1011;

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_ir;
  logic              r_illegal;

  logic [3:0]        w_opcode;
  logic [OPND_W-1:0] w_operand;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_imm;

  assign w_opcode  = r_ir[DATA_W-1:DATA_W-4];
  assign w_operand = r_ir[DATA_W-5:0];
  assign w_addr    = w_operand[ADDR_W-1:0];

`ifdef MU02_SIGN_EXT_EN
  assign w_imm = {{4{w_operand[OPND_W-1]}}, w_operand};
`else
  assign w_imm = {4'b0000, w_operand};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_FETCH: begin
        if (bus.mem_ack) w_next_state = c_EXEC;
      end
      c_EXEC: begin
        case (w_opcode)
          c_LDA, c_STO, c_ADD, c_SUB:                  w_next_state = c_MEM;
          c_LDAI, c_ADDI, c_SUBI, c_JMP, c_JGE, c_JNE: w_next_state = c_FETCH;
          default:                                     w_next_state = c_HALT;
        endcase
      end
      c_MEM: begin
        if (bus.mem_ack) w_next_state = c_FETCH;
      end
      default: w_next_state = c_HALT;
    endcase
  end

  // Bus strobes are pure decodes of held registers; reset gates req off asynchronously.
  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = r_pc;
    bus.mem_wdata = r_acc;
    halted        = 1'b0;
    case (r_state)
      c_FETCH: begin
        bus.mem_req = reset;
      end
      c_MEM: begin
        bus.mem_req  = reset;
        bus.mem_we   = reset & (w_opcode == c_STO);
        bus.mem_addr = w_addr;
      end
      c_HALT: begin
        halted = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc      <= '0;
      r_acc     <= '0;
      r_ir      <= '0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        c_FETCH: begin
          if (bus.mem_ack) begin
            r_ir <= bus.mem_rdata;
            r_pc <= r_pc + ADDR_W'(1);
          end
        end
        c_EXEC: begin
          case (w_opcode)
            c_LDAI: r_acc <= w_imm;
            c_ADDI: r_acc <= r_acc + w_imm;
            c_SUBI: r_acc <= r_acc - w_imm;
            c_JMP:  r_pc  <= w_addr;
            c_JGE:  if (!r_acc[DATA_W-1]) r_pc <= w_addr;
            c_JNE:  if (r_acc != '0) r_pc <= w_addr;
            c_LDA, c_STO, c_ADD, c_SUB, c_STP: ;
            default: r_illegal <= 1'b1;
          endcase
        end
        c_MEM: begin
          if (bus.mem_ack) begin
            case (w_opcode)
              c_LDA:   r_acc <= bus.mem_rdata;
              c_ADD:   r_acc <= r_acc + bus.mem_rdata;
              c_SUB:   r_acc <= r_acc - bus.mem_rdata;
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  assign illegal = r_illegal;
  assign pc_o    = r_pc;
  assign acc_o   = r_acc;
endmodule
`default_nettype wire
